// File: rtl/mmu_hdma_sched_if.sv
// Bundle between the per-region MMUs, the host XDMA command channel and the host data mux.
// Pure wiring, no latency.
// Commands and ordering records use valid/ready; completions are unconditional one-cycle pulses.
interface mmu_hdma_sched_if #(
   parameter int N_REQ     = 4,
   parameter int ADDR_BITS = 64,
   parameter int LEN_BITS  = 28
);
   localparam int ID_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // per-region request side
   logic [N_REQ-1:0]           s_req_valid;
   logic [N_REQ-1:0]           s_req_ready;
   logic [N_REQ*ADDR_BITS-1:0] s_req_paddr;
   logic [N_REQ*LEN_BITS-1:0]  s_req_len;
   logic [N_REQ-1:0]           s_req_last;

   // XDMA command channel
   logic                       m_req_valid;
   logic                       m_req_ready;
   logic [ADDR_BITS-1:0]       m_req_paddr;
   logic [LEN_BITS-1:0]        m_req_len;
   logic                       m_req_last;

   // ordering record to the host data mux
   logic                       m_mux_valid;
   logic                       m_mux_ready;
   logic [ID_BITS-1:0]         m_mux_id;
   logic [LEN_BITS-1:0]        m_mux_len;

   // completions and status
   logic                       s_done_valid;
   logic [ID_BITS-1:0]         s_done_id;
   logic [N_REQ-1:0]           outst_full;
   logic                       err_underflow;

   // scheduler side
   modport slave (
      input  s_req_valid, s_req_paddr, s_req_len, s_req_last,
      output s_req_ready,
      output m_req_valid, m_req_paddr, m_req_len, m_req_last,
      input  m_req_ready,
      output m_mux_valid, m_mux_id, m_mux_len,
      input  m_mux_ready,
      input  s_done_valid, s_done_id,
      output outst_full, err_underflow
   );

   // requester / channel / mux side
   modport master (
      output s_req_valid, s_req_paddr, s_req_len, s_req_last,
      input  s_req_ready,
      input  m_req_valid, m_req_paddr, m_req_len, m_req_last,
      output m_req_ready,
      input  m_mux_valid, m_mux_id, m_mux_len,
      output m_mux_ready,
      output s_done_valid, s_done_id,
      input  outst_full, err_underflow
   );
endinterface

// File: rtl/mmu_hdma_sched.sv
// Round-robin host-DMA command scheduler with per-region outstanding limit and ordering records.
// Latency: grant at t, command and ordering record valid at t+1; one command per 2 cycles at best.
// Backpressure: holds both outputs stable until each handshakes; no new grant until both have; s_req_ready never sees m_*_ready.
module mmu_hdma_sched #(
   parameter int N_REQ     = 4,
   parameter int ADDR_BITS = 64,
   parameter int LEN_BITS  = 28,
   parameter int MAX_OUTST = 8
) (
   input  logic             aclk,
   input  logic             areset,
   mmu_hdma_sched_if.slave  bus
);
   localparam int ID_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   localparam logic [7:0] CNT_MAX = 8'(MAX_OUTST);

   logic [0:0]              state;
   logic [ID_BITS-1:0]      rr_ptr;
   logic [N_REQ-1:0][7:0]   cnt;
   logic [N_REQ-1:0][7:0]   cnt_next;
   logic [N_REQ-1:0]        full;
   logic                    underflow;
   logic                    underflow_hit;

   logic                    req_vld_q;
   logic                    mux_vld_q;
   logic [ADDR_BITS-1:0]    paddr_q;
   logic [LEN_BITS-1:0]     len_q;
   logic                    last_q;
   logic [ID_BITS-1:0]      id_q;

   logic [N_REQ-1:0]        eligible;
   logic                    grant_found;
   logic [ID_BITS-1:0]      grant_idx;
   logic                    grant_take;
   logic [N_REQ-1:0]        ready_vec;
   logic                    done_ok;

   // A region at its limit is simply invisible to the arbiter, so the rotation order of the others is kept.
   assign eligible = bus.s_req_valid & ~full;

   // Rotating priority search starting just after the last granted region.
   always_comb begin
      int j;
      j           = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(rr_ptr) + k) % N_REQ;
         if (!grant_found && eligible[j]) begin
            grant_found = 1'b1;
            grant_idx   = ID_BITS'(j);
         end
      end
   end

   // Grants only happen from IDLE, so the accept path is independent of downstream ready.
   assign grant_take = (state == ST_IDLE) && grant_found && !areset;

   // One-hot accept towards the winning region.
   always_comb begin
      ready_vec = '0;
      if (grant_take) begin
         ready_vec[grant_idx] = 1'b1;
      end
   end

   // Completion ids outside the region range are dropped silently.
   assign done_ok = bus.s_done_valid && (int'(bus.s_done_id) < N_REQ);

   // Next outstanding counts: a grant and a completion to the same region cancel out.
   always_comb begin
      logic inc_i;
      logic dec_i;
      inc_i         = 1'b0;
      dec_i         = 1'b0;
      cnt_next      = cnt;
      underflow_hit = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         inc_i = grant_take && (int'(grant_idx) == i);
         dec_i = done_ok && (int'(bus.s_done_id) == i);
         if (inc_i && !dec_i) begin
            cnt_next[i] = cnt[i] + 8'd1;
         end else if (dec_i && !inc_i) begin
            if (cnt[i] == 8'd0) begin
               underflow_hit = 1'b1;
            end else begin
               cnt_next[i] = cnt[i] - 8'd1;
            end
         end
      end
   end

   // Counter, full flags (kept in step with cnt) and the sticky underflow flag.
   always_ff @(posedge aclk) begin
      if (areset) begin
         cnt       <= '0;
         full      <= '0;
         underflow <= 1'b0;
      end else begin
         cnt <= cnt_next;
         for (int i = 0; i < N_REQ; i++) begin
            full[i] <= (cnt_next[i] == CNT_MAX);
         end
         if (underflow_hit) begin
            underflow <= 1'b1;
         end
      end
   end

   // IDLE captures the winner; ISSUE drains command and ordering record independently.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= ST_IDLE;
         rr_ptr    <= ID_BITS'(N_REQ - 1);
         req_vld_q <= 1'b0;
         mux_vld_q <= 1'b0;
         paddr_q   <= '0;
         len_q     <= '0;
         last_q    <= 1'b0;
         id_q      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_take) begin
                  paddr_q   <= bus.s_req_paddr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
                  len_q     <= bus.s_req_len[int'(grant_idx)*LEN_BITS +: LEN_BITS];
                  last_q    <= bus.s_req_last[grant_idx];
                  id_q      <= grant_idx;
                  rr_ptr    <= grant_idx;
                  req_vld_q <= 1'b1;
                  mux_vld_q <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (req_vld_q && bus.m_req_ready) begin
                  req_vld_q <= 1'b0;
               end
               if (mux_vld_q && bus.m_mux_ready) begin
                  mux_vld_q <= 1'b0;
               end
               if ((!req_vld_q || bus.m_req_ready) && (!mux_vld_q || bus.m_mux_ready)) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.s_req_ready   = ready_vec;
   assign bus.m_req_valid   = req_vld_q;
   assign bus.m_req_paddr   = paddr_q;
   assign bus.m_req_len     = len_q;
   assign bus.m_req_last    = last_q;
   assign bus.m_mux_valid   = mux_vld_q;
   assign bus.m_mux_id      = id_q;
   assign bus.m_mux_len     = len_q;
   assign bus.outst_full    = full;
   assign bus.err_underflow = underflow;
endmodule

// File: tb/tb_mmu_hdma_sched.sv
// Bench for mmu_hdma_sched: directed scenarios with a queue/integer reference model.
// Model is advanced on every rising edge and compared on every falling edge.
// Literal expectations from hand analysis pin both the model and the design.
module tb_mmu_hdma_sched;
   localparam int N_REQ     = 4;
   localparam int ADDR_BITS = 64;
   localparam int LEN_BITS  = 28;
   localparam int MAX_OUTST = 8;
   localparam int ID_BITS   = 2;

   logic aclk;
   logic areset;

   mmu_hdma_sched_if #(.N_REQ(N_REQ), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) bus ();

   mmu_hdma_sched #(
      .N_REQ(N_REQ), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .MAX_OUTST(MAX_OUTST)
   ) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   int checks = 0;
   int errors = 0;

   // reference model state
   int  cnt_m [N_REQ];
   bit  err_m;
   int  rr_m;
   bit  busy, req_pend, mux_pend;
   int  e_id;
   int  cyc = 0;
   bit  last_req_hs;
   int  last_req_id;
   bit  auto_done;
   int  m_grants[$];

   // observed design activity
   int          d_grants[$];
   int          d_grant_cyc[$];
   logic [63:0] d_req_paddr[$];
   int          d_mux_id[$];

   function automatic logic [63:0] paddr_of(input int i);
      return 64'h0000_00AB_0000_0000 + 64'(i) * 64'h100;
   endfunction

   function automatic logic [LEN_BITS-1:0] len_of(input int i);
      return LEN_BITS'(100 + i);
   endfunction

   function automatic logic last_of(input int i);
      return (i % 2) == 1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Which region the scheduler must accept right now, or -1.
   function automatic int exp_grant();
      int j;
      if (areset || busy) return -1;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (rr_m + k) % N_REQ;
         if (bus.s_req_valid[j] && cnt_m[j] < MAX_OUTST) return j;
      end
      return -1;
   endfunction

   // Model advance on each rising edge.
   always @(posedge aclk) begin
      int g;
      int d;
      g = exp_grant();
      last_req_hs = 1'b0;
      if (areset) begin
         for (int i = 0; i < N_REQ; i++) cnt_m[i] = 0;
         err_m = 1'b0; rr_m = N_REQ - 1;
         busy = 1'b0; req_pend = 1'b0; mux_pend = 1'b0; e_id = 0;
      end else begin
         if (busy) begin
            if (req_pend && bus.m_req_ready) begin
               req_pend = 1'b0; last_req_hs = 1'b1; last_req_id = e_id;
            end
            if (mux_pend && bus.m_mux_ready) mux_pend = 1'b0;
            if (!req_pend && !mux_pend) busy = 1'b0;
         end else if (g >= 0) begin
            busy = 1'b1; req_pend = 1'b1; mux_pend = 1'b1;
            e_id = g; rr_m = g;
            m_grants.push_back(g);
         end
         for (int i = 0; i < N_REQ; i++) begin
            d = ((g == i) ? 1 : 0) - ((bus.s_done_valid && int'(bus.s_done_id) == i) ? 1 : 0);
            if (d > 0) cnt_m[i] = cnt_m[i] + 1;
            else if (d < 0) begin
               if (cnt_m[i] == 0) err_m = 1'b1;
               else cnt_m[i] = cnt_m[i] - 1;
            end
         end
      end
      cyc++;
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge aclk) begin
      if (cyc > 0) begin
         int g;
         logic [N_REQ-1:0] er, ef;
         g  = exp_grant();
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         ef = '0;
         for (int i = 0; i < N_REQ; i++) ef[i] = (cnt_m[i] == MAX_OUTST);
         chk("s_req_ready", 64'(bus.s_req_ready), 64'(er));
         chk("m_req_valid", 64'(bus.m_req_valid), 64'(req_pend));
         chk("m_mux_valid", 64'(bus.m_mux_valid), 64'(mux_pend));
         if (req_pend) begin
            chk("m_req_paddr", bus.m_req_paddr, paddr_of(e_id));
            chk("m_req_len", 64'(bus.m_req_len), 64'(len_of(e_id)));
            chk("m_req_last", 64'(bus.m_req_last), 64'(last_of(e_id)));
         end
         if (mux_pend) begin
            chk("m_mux_id", 64'(bus.m_mux_id), 64'(e_id));
            chk("m_mux_len", 64'(bus.m_mux_len), 64'(len_of(e_id)));
         end
         chk("outst_full", 64'(bus.outst_full), 64'(ef));
         chk("err_underflow", 64'(bus.err_underflow), 64'(err_m));
         for (int i = 0; i < N_REQ; i++) chk("cnt", 64'(dut.cnt[i]), 64'(cnt_m[i]));
         for (int i = 0; i < N_REQ; i++) begin
            if (bus.s_req_ready[i]) begin
               d_grants.push_back(i);
               d_grant_cyc.push_back(cyc);
            end
         end
         if (bus.m_req_valid && bus.m_req_ready) d_req_paddr.push_back(bus.m_req_paddr);
         if (bus.m_mux_valid && bus.m_mux_ready) d_mux_id.push_back(int'(bus.m_mux_id));
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
      if (auto_done) begin
         bus.s_done_valid = last_req_hs;
         bus.s_done_id    = ID_BITS'(last_req_id);
      end
   endtask

   task automatic do_reset();
      areset           = 1'b1;
      auto_done        = 1'b0;
      bus.s_req_valid  = '0;
      bus.s_done_valid = 1'b0;
      bus.s_done_id    = '0;
      bus.m_req_ready  = 1'b1;
      bus.m_mux_ready  = 1'b1;
      tick();
      tick();
      areset = 1'b0;
   endtask

   // Run until the model has recorded n grants since index b, bounded.
   task automatic run_grants(input int b, input int n, input string name);
      int t;
      t = 0;
      while (m_grants.size() - b < n && t < 60) begin
         tick();
         t++;
      end
      if (t >= 60) chk({name, "_timeout"}, 64'(m_grants.size() - b), 64'(n));
   endtask

   initial begin
      int b, db, rb, xb, c, t;
      int exp1[6];
      exp1 = '{0, 1, 2, 3, 0, 1};
      areset           = 1'b1;
      auto_done        = 1'b0;
      bus.s_req_valid  = '0;
      bus.s_done_valid = 1'b0;
      bus.s_done_id    = '0;
      bus.m_req_ready  = 1'b1;
      bus.m_mux_ready  = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         bus.s_req_paddr[i*ADDR_BITS +: ADDR_BITS] = paddr_of(i);
         bus.s_req_len[i*LEN_BITS +: LEN_BITS]     = len_of(i);
         bus.s_req_last[i]                         = last_of(i);
      end

      // reset state
      tick(); tick();
      chk("rst_m_req_valid", 64'(bus.m_req_valid), 64'd0);
      chk("rst_m_mux_valid", 64'(bus.m_mux_valid), 64'd0);
      chk("rst_paddr", bus.m_req_paddr, 64'd0);
      chk("rst_len", 64'(bus.m_req_len), 64'd0);
      chk("rst_mux_id", 64'(bus.m_mux_id), 64'd0);
      chk("rst_full", 64'(bus.outst_full), 64'd0);
      chk("rst_err", 64'(bus.err_underflow), 64'd0);
      chk("rst_ready", 64'(bus.s_req_ready), 64'd0);

      // all regions busy, immediate completions
      do_reset();
      auto_done = 1'b1;
      b = m_grants.size(); db = d_grants.size(); rb = d_req_paddr.size(); xb = d_mux_id.size();
      bus.s_req_valid = '1;
      run_grants(b, 6, "s1");
      bus.s_req_valid = '0;
      repeat (4) tick();
      chk("s1_grant_count", 64'(d_grants.size() - db), 64'd6);
      for (int i = 0; i < 6; i++) begin
         chk("s1_model_grant", 64'((m_grants.size() > b + i) ? m_grants[b+i] : -1), 64'(exp1[i]));
         chk("s1_dut_grant", 64'((d_grants.size() > db + i) ? d_grants[db+i] : -1), 64'(exp1[i]));
         chk("s1_mux_order", 64'((d_mux_id.size() > xb + i) ? d_mux_id[xb+i] : -1), 64'(exp1[i]));
         chk("s1_req_order", (d_req_paddr.size() > rb + i) ? d_req_paddr[rb+i] : 64'hFFFF, paddr_of(exp1[i]));
      end
      for (int i = 1; i < 6; i++) begin
         if (d_grant_cyc.size() > db + i)
            chk("s1_spacing", 64'(d_grant_cyc[db+i] - d_grant_cyc[db+i-1]), 64'd2);
      end

      // region 2 alone up to the limit, then one completion frees a slot
      do_reset();
      b = m_grants.size(); db = d_grants.size();
      bus.s_req_valid = 4'b0100;
      repeat (20) tick();
      chk("s2_model_grants", 64'(m_grants.size() - b), 64'd8);
      chk("s2_dut_grants", 64'(d_grants.size() - db), 64'd8);
      chk("s2_full", 64'(bus.outst_full), 64'b0100);
      chk("s2_ready", 64'(bus.s_req_ready), 64'd0);
      chk("s2_cnt", 64'(dut.cnt[2]), 64'd8);
      bus.s_done_valid = 1'b1; bus.s_done_id = 2'd2;
      c = cyc;
      tick();
      bus.s_done_valid = 1'b0;
      tick(); tick();
      chk("s2_ninth_grant", 64'(d_grants.size() - db), 64'd9);
      chk("s2_ninth_latency", 64'(d_grant_cyc.size() > 0 ? d_grant_cyc[d_grant_cyc.size()-1] - c : -1), 64'd1);

      // command channel accepts, mux stalls for 5 cycles
      do_reset();
      db = d_grants.size(); rb = d_req_paddr.size(); xb = d_mux_id.size();
      bus.m_mux_ready = 1'b0;
      bus.s_req_valid = 4'b0001;
      tick();
      repeat (5) tick();
      chk("s3_req_hs_once", 64'(d_req_paddr.size() - rb), 64'd1);
      chk("s3_no_new_grant", 64'(d_grants.size() - db), 64'd1);
      chk("s3_mux_valid", 64'(bus.m_mux_valid), 64'd1);
      chk("s3_mux_len", 64'(bus.m_mux_len), 64'(len_of(0)));
      bus.m_mux_ready = 1'b1;
      tick(); tick();
      chk("s3_mux_hs", 64'(d_mux_id.size() - xb), 64'd1);
      chk("s3_next_grant", 64'(d_grants.size() - db), 64'd2);

      // roles swapped: mux accepts, command channel stalls
      do_reset();
      db = d_grants.size(); rb = d_req_paddr.size(); xb = d_mux_id.size();
      bus.m_req_ready = 1'b0;
      bus.s_req_valid = 4'b1000;
      tick();
      repeat (5) tick();
      chk("s3b_mux_hs_once", 64'(d_mux_id.size() - xb), 64'd1);
      chk("s3b_no_new_grant", 64'(d_grants.size() - db), 64'd1);
      chk("s3b_req_valid", 64'(bus.m_req_valid), 64'd1);
      chk("s3b_req_paddr", bus.m_req_paddr, paddr_of(3));
      bus.m_req_ready = 1'b1;
      tick(); tick();
      chk("s3b_req_hs", 64'(d_req_paddr.size() - rb), 64'd1);
      chk("s3b_next_grant", 64'(d_grants.size() - db), 64'd2);

      // same-cycle grant and completion on region 1 at cnt 3
      do_reset();
      b = m_grants.size();
      bus.s_req_valid = 4'b0010;
      run_grants(b, 3, "s4");
      bus.s_req_valid = '0;
      repeat (3) tick();
      chk("s4_cnt_before", 64'(dut.cnt[1]), 64'd3);
      bus.s_req_valid  = 4'b0010;
      bus.s_done_valid = 1'b1; bus.s_done_id = 2'd1;
      tick();
      bus.s_req_valid  = '0;
      bus.s_done_valid = 1'b0;
      tick(); tick();
      chk("s4_grants", 64'(m_grants.size() - b), 64'd4);
      chk("s4_cnt_after", 64'(dut.cnt[1]), 64'd3);
      chk("s4_model_cnt", 64'(cnt_m[1]), 64'd3);
      chk("s4_no_err", 64'(bus.err_underflow), 64'd0);

      // completion with nothing outstanding
      do_reset();
      bus.s_done_valid = 1'b1; bus.s_done_id = 2'd0;
      tick();
      bus.s_done_valid = 1'b0;
      tick();
      chk("s5_err", 64'(bus.err_underflow), 64'd1);
      chk("s5_cnt0", 64'(dut.cnt[0]), 64'd0);
      repeat (3) tick();
      chk("s5_err_sticky", 64'(bus.err_underflow), 64'd1);

      // reset in the middle of ISSUE with cnt[1] = 5
      do_reset();
      b = m_grants.size();
      bus.s_req_valid = 4'b0010;
      run_grants(b, 5, "s6");
      bus.m_req_ready = 1'b0;
      bus.m_mux_ready = 1'b0;
      chk("s6_cnt_before", 64'(dut.cnt[1]), 64'd5);
      chk("s6_in_issue", 64'(bus.m_req_valid), 64'd1);
      bus.s_req_valid = '1;
      areset = 1'b1;
      tick();
      chk("s6_req_dropped", 64'(bus.m_req_valid), 64'd0);
      chk("s6_mux_dropped", 64'(bus.m_mux_valid), 64'd0);
      for (int i = 0; i < N_REQ; i++) chk("s6_cnt_cleared", 64'(dut.cnt[i]), 64'd0);
      db = d_grants.size();
      areset = 1'b0;
      bus.m_req_ready = 1'b1;
      bus.m_mux_ready = 1'b1;
      tick();
      bus.s_req_valid = '0;
      t = (d_grants.size() > db) ? d_grants[db] : -1;
      chk("s6_first_grant_region0", 64'(t), 64'd0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mmu_hdma_sched.md
# mmu_hdma_sched

Host-DMA request scheduler for the MMU top level. It shares the single host XDMA command channel between the per-region MMUs using round-robin, with a per-region outstanding-request limit. For every issued command it emits an ordering record (region id, length) for the host data mux. Completions retire outstanding slots so no region can monopolise the channel or overrun its data buffering.

## Interface
Parameters:
- N_REQ, 4: number of requesting regions (1..16).
- ADDR_BITS, 64: physical address width.
- LEN_BITS, 28: transfer length width.
- MAX_OUTST, 8: maximum outstanding commands per region (1..255).
- ID_BITS, max(1, clog2(N_REQ)): derived, not overridable.

Ports:
- aclk  in  1  clock; everything is on the rising edge.
- areset  in  1  reset; synchronous and active-high.
- s_req_valid  in  N_REQ  per-region command valid.
- s_req_ready  out  N_REQ  per-region accept; at most one bit set.
- s_req_paddr  in  N_REQ*ADDR_BITS  per-region address, region i at slice [i*ADDR_BITS +: ADDR_BITS].
- s_req_len  in  N_REQ*LEN_BITS  per-region length, same slicing.
- s_req_last  in  N_REQ  per-region last flag.
- m_req_valid  out  1  command to XDMA.
- m_req_ready  in  1  XDMA accept.
- m_req_paddr, m_req_len, m_req_last  out  ADDR_BITS/LEN_BITS/1  granted command fields.
- m_mux_valid  out  1  ordering record valid.
- m_mux_ready  in  1  mux accept.
- m_mux_id  out  ID_BITS  granted region.
- m_mux_len  out  LEN_BITS  granted length.
- s_done_valid  in  1  completion pulse, one per command.
- s_done_id  in  ID_BITS  region of the completion.
- outst_full  out  N_REQ  region at MAX_OUTST.
- err_underflow  out  1  sticky flag: completion arrived for a region with zero outstanding.

## Operation
- FSM states:
  - IDLE: eligible[i] = s_req_valid[i] & ~outst_full[i]. If any bit is eligible, grant the first eligible index after rr_ptr (wrapping).
    - Same cycle: assert s_req_ready[grant].
    - Register paddr/len/last/id into the output registers.
    - Set rr_ptr = grant and increment cnt[grant].
    - Go to ISSUE.
  - ISSUE: m_req_valid and m_mux_valid rise together. Each deasserts independently after its own handshake; outputs hold stable while valid. Once both have handshaken (same or different cycles), go to IDLE. No grant is made in ISSUE.
- s_req_ready is combinational from the IDLE state and eligibility. It never depends on m_req_ready.
- Counters cnt[i] are 8 bits wide. outst_full[i] = (cnt[i] == MAX_OUTST), registered from cnt.
- s_done_valid decrements cnt[s_done_id].
- Increment and decrement to the same region in the same cycle: cnt is unchanged.
- Decrement when cnt is 0: cnt stays 0 and err_underflow is set. It clears only on reset.
- s_done_id >= N_REQ is ignored.
- Requests whose region is at the limit are skipped. The round-robin order among the remaining regions is preserved.
- Reset values:
  - FSM = IDLE, rr_ptr = N_REQ-1 (region 0 wins first), all cnt = 0.
  - m_req_valid = m_mux_valid = 0, s_req_ready = 0, outst_full = 0, err_underflow = 0.
  - Data outputs = 0.
- Reset mid-ISSUE drops the in-flight command and ordering record, and clears all counters.

## Timing
- Grant in cycle t (s_req_valid & s_req_ready) gives m_req_valid and m_mux_valid high at t+1.
- Minimum spacing is 2 cycles per command (IDLE then ISSUE), so peak throughput is 1 command per 2 cycles.
- The counter update from a grant or completion in cycle t is visible in cnt and outst_full at t+1.
- A completion in cycle t can enable a grant to that region at t+1 at the earliest.
- m_req and m_mux are both AXI-style valid/ready: once asserted, valid stays high and the fields stay stable until ready.
- No combinational path from m_req_ready or m_mux_ready to s_req_ready.

## Test plan
- Reset, then regions 0..3 all valid continuously with MAX_OUTST=8 and immediate completions.
  - Grants: 0,1,2,3,0,1.
  - m_mux_id matches m_req order.
  - One command every 2 cycles.
- Region 2 only, 8 requests with no completions.
  - 8 grants, then outst_full[2]=1 and s_req_ready[2] stays 0.
  - One s_done_valid with id 2 gives a ninth grant exactly 1 cycle later.
- Backpressure, with command fields held.
  - m_req_ready=1 with m_mux_ready=0 for 5 cycles: m_req handshakes once, m_mux_valid stays high with fields stable, and no new grant until the m_mux handshake.
  - Repeat with the roles swapped.
- Same-cycle grant and completion for region 1 with cnt=3: cnt stays 3.
- Completion for region 0 with cnt=0: err_underflow=1, cnt stays 0.
- Assert areset during ISSUE with cnt[1]=5.
  - Next cycle: m_req_valid=0, all cnt=0.
  - Region 0 wins the first grant after reset.
